// File: rtl/processor_system_nios2_cpu_ocimem_master_if.sv
// Avalon-MM master bus bundle used by the OCI memory master.
// The master drives address/control/write data; the slave returns stall and read data.
interface processor_system_nios2_cpu_ocimem_master_if;
  logic [31:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  modport master (
    output av_address,
    output av_read,
    output av_write,
    output av_writedata,
    output av_byteenable,
    input  av_waitrequest,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_read,
    input  av_write,
    input  av_writedata,
    input  av_byteenable,
    output av_waitrequest,
    output av_readdata
  );
endinterface

// File: rtl/processor_system_nios2_cpu_ocimem_master.sv
// JTAG debug OCI memory master: turns single-cycle debug strobes into Avalon-MM
// word reads and writes with an auto-incrementing address register.
// Optional waitrequest timeout is compiled in with PROCESSOR_SYSTEM_OCIMEM_TIMEOUT_EN.
module processor_system_nios2_cpu_ocimem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  processor_system_nios2_cpu_ocimem_master_if.master av,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e      state_q;
  logic [29:0] mon_a_q;
  logic [31:0] mon_d_q;
  logic        read_q;
  logic        write_q;
  logic        ready_q;
  logic        error_q;
  logic        any_strobe;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

`ifdef PROCESSOR_SYSTEM_OCIMEM_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
`endif

  // Only the address field, the read flag and the write-data field of jdo are consumed.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Access FSM; every output it drives is a register so the bus sees clean levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      mon_a_q <= '0;
      mon_d_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
`ifdef PROCESSOR_SYSTEM_OCIMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
`ifdef PROCESSOR_SYSTEM_OCIMEM_TIMEOUT_EN
          cnt_q <= '0;
`endif
          // Strobe priority: ocimem_a, then ocimem_b, then no_action_a.
          if (take_action_ocimem_a) begin
            mon_a_q <= jdo[33:4];
            error_q <= 1'b0;
            if (jdo[35]) begin
              state_q <= StRead;
              read_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end else if (take_action_ocimem_b) begin
            mon_d_q <= jdo[34:3];
            state_q <= StWrite;
            write_q <= 1'b1;
            ready_q <= 1'b0;
          end else if (take_no_action_ocimem_a) begin
            state_q <= StRead;
            read_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        StRead, StWrite: begin
          // A strobe during an access is dropped but flagged.
          if (any_strobe) begin
            error_q <= 1'b1;
          end
          if (!av.av_waitrequest) begin
            if (state_q == StRead) begin
              mon_d_q <= av.av_readdata;
            end
            mon_a_q <= mon_a_q + 30'd1;
            state_q <= StIdle;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef PROCESSOR_SYSTEM_OCIMEM_TIMEOUT_EN
            cnt_q   <= '0;
          end else if (cnt_q == TimeoutLast) begin
            // Abort: leave address and data untouched, report via the sticky error.
            state_q <= StIdle;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            error_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign av.av_address    = {mon_a_q, 2'b00};
  assign av.av_read       = read_q;
  assign av.av_write      = write_q;
  assign av.av_writedata  = mon_d_q;
  assign av.av_byteenable = 4'hF;
  assign MonDReg          = mon_d_q;
  assign monitor_ready    = ready_q;
  assign monitor_error    = error_q;

endmodule

// File: tb/tb_processor_system_nios2_cpu_ocimem_master.sv
// Directed bench for the OCI memory master; expectations are hand-computed.
// Build with PROCESSOR_SYSTEM_OCIMEM_TIMEOUT_EN to exercise the timeout path.
module tb_processor_system_nios2_cpu_ocimem_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_checks = 0;
  int n_fail = 0;

  processor_system_nios2_cpu_ocimem_master_if av_if ();

  processor_system_nios2_cpu_ocimem_master #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .av                     (av_if),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic [29:0] wa);
    return {2'b00, rd, 1'b0, wa, 4'b0000};
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    return {2'b00, 1'b0, d, 3'b000};
  endfunction

  // Drive strobes for one clock; returns at the negedge after the capturing posedge.
  task automatic strobe(input logic a, input logic b, input logic na, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    take_no_action_ocimem_a = na;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    logic held;
    av_if.av_waitrequest = 1'b1;
    av_if.av_readdata = 32'h0;

    // Reset values
    #12;
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_read", 32'(av_if.av_read), 32'd0);
    chk("rst_write", 32'(av_if.av_write), 32'd0);
    chk("rst_addr", av_if.av_address, 32'h0);
    chk("rst_dreg", MonDReg, 32'h0);
    chk("rst_err", 32'(monitor_error), 32'd0);
    chk("byteen", 32'(av_if.av_byteenable), 32'hF);
    @(negedge clk);
    reset_n = 1'b1;

    // Addressed read, slave stalls then returns data
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 30'h0000100));
    chk("rd_read", 32'(av_if.av_read), 32'd1);
    chk("rd_addr", av_if.av_address, 32'h00000400);
    chk("rd_busy", 32'(monitor_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    av_if.av_waitrequest = 1'b0;
    av_if.av_readdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_done_read", 32'(av_if.av_read), 32'd0);
    chk("rd_dreg", MonDReg, 32'hDEADBEEF);
    chk("rd_next_addr", av_if.av_address, 32'h00000404);
    chk("rd_ready", 32'(monitor_ready), 32'd1);

    // Write, no stall
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
    chk("wr_write", 32'(av_if.av_write), 32'd1);
    chk("wr_data", av_if.av_writedata, 32'h12345678);
    chk("wr_addr", av_if.av_address, 32'h00000404);
    @(negedge clk);
    chk("wr_done_write", 32'(av_if.av_write), 32'd0);
    chk("wr_next_addr", av_if.av_address, 32'h00000408);
    chk("wr_err", 32'(monitor_error), 32'd0);
    chk("wr_dreg", MonDReg, 32'h12345678);
    chk("wr_ready", 32'(monitor_ready), 32'd1);

    // Address wrap at top of memory
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 30'h3FFFFFFF));
    chk("top_addr", av_if.av_address, 32'hFFFFFFFC);
    chk("top_idle", 32'(av_if.av_read), 32'd0);
    av_if.av_readdata = 32'hCAFEF00D;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    chk("wrap_read", 32'(av_if.av_read), 32'd1);
    @(negedge clk);
    chk("wrap_addr", av_if.av_address, 32'h00000000);
    chk("wrap_dreg", MonDReg, 32'hCAFEF00D);

    // All strobes together: ocimem_a wins, no write, no error
    strobe(1'b1, 1'b1, 1'b1, jdo_a(1'b0, 30'h10));
    chk("prio_addr", av_if.av_address, 32'h00000040);
    chk("prio_dreg", MonDReg, 32'hCAFEF00D);
    chk("prio_write", 32'(av_if.av_write), 32'd0);
    chk("prio_read", 32'(av_if.av_read), 32'd0);
    chk("prio_err", 32'(monitor_error), 32'd0);

    // Strobe during a read: ignored, sticky error
    av_if.av_waitrequest = 1'b1;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    chk("busy_read", 32'(av_if.av_read), 32'd1);
    jdo = jdo_a(1'b1, 30'h3333);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    chk("busy_err", 32'(monitor_error), 32'd1);
    chk("busy_still_read", 32'(av_if.av_read), 32'd1);
    chk("busy_addr", av_if.av_address, 32'h00000040);
    av_if.av_waitrequest = 1'b0;
    av_if.av_readdata = 32'h0BADCAFE;
    @(negedge clk);
    chk("busy_done", 32'(av_if.av_read), 32'd0);
    chk("busy_dreg", MonDReg, 32'h0BADCAFE);
    chk("busy_next_addr", av_if.av_address, 32'h00000044);
    chk("busy_err_sticky", 32'(monitor_error), 32'd1);
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 30'h20));
    chk("err_clear", 32'(monitor_error), 32'd0);
    chk("err_clear_addr", av_if.av_address, 32'h00000080);

    // Slave stuck in waitrequest
    av_if.av_waitrequest = 1'b1;
    av_if.av_readdata = 32'h55AA55AA;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    chk("stuck_read0", 32'(av_if.av_read), 32'd1);
`ifdef PROCESSOR_SYSTEM_OCIMEM_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("stuck_read_hold", 32'(av_if.av_read), 32'd1);
    end
    @(negedge clk);
    chk("to_read", 32'(av_if.av_read), 32'd0);
    chk("to_err", 32'(monitor_error), 32'd1);
    chk("to_dreg", MonDReg, 32'h0BADCAFE);
    chk("to_addr", av_if.av_address, 32'h00000080);
    chk("to_ready", 32'(monitor_ready), 32'd1);
`else
    held = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      held = held & av_if.av_read;
    end
    chk("stuck_read_held", 32'(held), 32'd1);
    chk("stuck_err", 32'(monitor_error), 32'd0);
    av_if.av_waitrequest = 1'b0;
    av_if.av_readdata = 32'h11112222;
    @(negedge clk);
    chk("stuck_done", 32'(av_if.av_read), 32'd0);
    chk("stuck_dreg", MonDReg, 32'h11112222);
    chk("stuck_addr", av_if.av_address, 32'h00000084);
`endif
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 30'h40));
    chk("norm_addr", av_if.av_address, 32'h00000100);
    chk("norm_err", 32'(monitor_error), 32'd0);

    // Reset in the middle of a stalled write
    av_if.av_waitrequest = 1'b1;
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'hA5A5A5A5));
    chk("mid_write", 32'(av_if.av_write), 32'd1);
    chk("mid_wdata", av_if.av_writedata, 32'hA5A5A5A5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_write", 32'(av_if.av_write), 32'd0);
    chk("arst_read", 32'(av_if.av_read), 32'd0);
    chk("arst_ready", 32'(monitor_ready), 32'd1);
    chk("arst_addr", av_if.av_address, 32'h0);
    chk("arst_dreg", MonDReg, 32'h0);
    chk("arst_err", 32'(monitor_error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    av_if.av_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ready", 32'(monitor_ready), 32'd1);
    chk("post_rst_write", 32'(av_if.av_write), 32'd0);
    chk("post_rst_read", 32'(av_if.av_read), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/processor_system_nios2_cpu_ocimem_master.md
PROCESSOR_SYSTEM_NIOS2_CPU_OCIMEM_MASTER -- requirements
Module: processor_system_nios2_cpu_ocimem_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 256, waitrequest cycles before an access is aborted (range 2..65535).
REQ-002 SHALL have port: clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: jdo  in  38  JTAG data word from sysclk-domain debug stage.
REQ-005 SHALL have port: take_action_ocimem_a  in  1  single-cycle strobe: load address, optional read.
REQ-006 SHALL have port: take_action_ocimem_b  in  1  single-cycle strobe: write data.
REQ-007 SHALL have port: take_no_action_ocimem_a  in  1  single-cycle strobe: read next word.
REQ-008 SHALL have port: av_waitrequest  in  1  slave stall; av_readdata valid in any cycle with av_read=1 and av_waitrequest=0.
REQ-009 SHALL have port: av_readdata  in  32  read data.
REQ-010 SHALL have ports: av_address out 32 (byte address, [1:0]=0); av_read out 1; av_write out 1; av_writedata out 32; av_byteenable out 4 (constant 4'hF).
REQ-011 SHALL have ports: MonDReg out 32 data register; monitor_ready out 1 idle/complete; monitor_error out 1 sticky error.

Function
REQ-012 SHALL hold MonAReg[31:2] internally; av_address = {MonAReg[31:2],2'b00}; av_writedata = MonDReg.
REQ-013 SHALL implement FSM IDLE, READ, WRITE; monitor_ready = 1 only in IDLE.
REQ-014 SHALL apply strobe priority when several are high in one cycle: ocimem_a > ocimem_b > no_action_a; lower-priority strobes are dropped without error.
REQ-015 SHALL, on ocimem_a in IDLE: MonAReg[31:2] <= jdo[33:4], monitor_error <= 0; if jdo[35]=1, enter READ next cycle, else stay IDLE.
REQ-016 SHALL, on ocimem_b in IDLE: MonDReg <= jdo[34:3], enter WRITE.
REQ-017 SHALL, on no_action_a in IDLE: enter READ.
REQ-018 SHALL assert av_read exactly in READ and av_write exactly in WRITE, both registered (first asserted cycle = strobe cycle + 1), held stable until accepted.
REQ-019 SHALL, on READ cycle with av_waitrequest=0: MonDReg <= av_readdata, MonAReg <= MonAReg+1, return to IDLE (monitor_ready high next cycle).
REQ-020 SHALL, on WRITE cycle with av_waitrequest=0: MonAReg <= MonAReg+1, return to IDLE; MonDReg unchanged.
REQ-021 SHALL wrap MonAReg modulo 2^30 (byte address 0xFFFFFFFC increments to 0x00000000).
REQ-022 SHALL ignore any strobe arriving in READ or WRITE (no register change, access continues) and set monitor_error <= 1.
REQ-023 SHALL clear monitor_error only via ocimem_a accepted in IDLE or reset.

Reset
REQ-024 SHALL, on reset_n low (any state, including mid-access), immediately force: FSM IDLE, av_read=0, av_write=0, MonAReg=0, MonDReg=0, monitor_error=0, timeout counter=0; monitor_ready=1.
REQ-025 SHALL resume normal operation on the first clk edge after reset_n deasserts; no strobe is remembered across reset.

Configuration
REQ-026 SHALL use macro PROCESSOR_SYSTEM_OCIMEM_TIMEOUT_EN to compile the timeout feature in or out.
REQ-027 SHALL, with macro defined: count consecutive READ/WRITE cycles with av_waitrequest=1; at count = TIMEOUT_CYCLES drop av_read/av_write, return to IDLE, set monitor_error=1, leave MonDReg and MonAReg unchanged; counter clears on every state entry.
REQ-028 SHALL, with macro undefined: contain no counter; READ/WRITE wait indefinitely; monitor_error set only per REQ-022.

Verification
REQ-029 SHALL cover: ocimem_a with jdo[33:4]=0x0000100, jdo[35]=1, waitrequest low 3 cycles later, readdata=0xDEADBEEF -> av_address=0x00000400, MonDReg=0xDEADBEEF, next av_address=0x00000404, monitor_ready high.
REQ-030 SHALL cover: ocimem_b with jdo[34:3]=0x12345678, waitrequest 0 -> one av_write cycle, av_writedata=0x12345678, address +4, monitor_error=0.
REQ-031 SHALL cover: address 0xFFFFFFFC, no_action_a read completes -> next av_address=0x00000000.
REQ-032 SHALL cover: no_action_a during an in-progress READ -> read completes unchanged, monitor_error=1 until next ocimem_a.
REQ-033 SHALL cover (macro defined, TIMEOUT_CYCLES=4): waitrequest stuck high -> av_read drops after 4 cycles, monitor_error=1, MonDReg unchanged; (macro undefined) -> av_read held 100+ cycles.
REQ-034 SHALL cover: reset_n low while av_write=1 and waitrequest=1 -> av_write=0 asynchronously, all outputs at REQ-024 values.
